// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display driver: mode encodings, blank segment
// pattern and the divider counter width helper.
package hex_display_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bits needed to hold the terminal count itself (never narrower than 1).
    function automatic int div_width(input int term);
        int w;
        w = $clog2(term + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seven_segment_display.sv
// Hex nibble to active-low seven-segment pattern; HEX[0]=a ... HEX[6]=g.
module seven_segment_display (
    input  logic [3:0] X,
    output logic [6:0] HEX
);

    always_comb begin
        HEX = 7'h7F;
        case (X)
            4'h0: HEX = 7'h40;
            4'h1: HEX = 7'h79;
            4'h2: HEX = 7'h24;
            4'h3: HEX = 7'h30;
            4'h4: HEX = 7'h19;
            4'h5: HEX = 7'h12;
            4'h6: HEX = 7'h02;
            4'h7: HEX = 7'h78;
            4'h8: HEX = 7'h00;
            4'h9: HEX = 7'h10;
            4'hA: HEX = 7'h08;
            4'hB: HEX = 7'h03;
            4'hC: HEX = 7'h46;
            4'hD: HEX = 7'h21;
            4'hE: HEX = 7'h06;
            4'hF: HEX = 7'h0E;
            default: HEX = 7'h7F;
        endcase
    end

endmodule

// File: rtl/tick_divider.sv
// Counts 0..DIV-1 and flags the terminal count; clr restarts the count.
module tick_divider
    import hex_display_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic clr,
    output logic tick
);

    localparam int             W    = div_width(DIV - 1);
    localparam logic [W-1:0]   TERM = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    assign tick = (r_cnt == TERM);

    always_ff @(posedge CLOCK_50) begin
        if (RESET || clr) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit hex value register with load/hold/up/down counting, driving
// active-low seven-segment displays with leading-zero blanking and blinking.
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int CLK_HZ   = 50_000_000,
    parameter int COUNT_HZ = 1,
    parameter int BLINK_HZ = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic [1:0]            MODE,
    input  logic                  BLANK_LZ,
    input  logic                  BLINK_EN,
    output logic [7*DIGITS-1:0]   HEX,
    output logic [4*DIGITS-1:0]   LEDR,
    output logic                  TICK,
    output logic                  WRAP
);

    localparam int               VW    = 4 * DIGITS;
    localparam logic [VW-1:0]    ALL_F = '1;

    logic [VW-1:0]         r_val;
    logic                  r_tick;
    logic                  r_wrap;
    logic                  r_phase;
    logic [7*DIGITS-1:0]   r_hex;

    logic                  w_step;
    logic                  w_blink_tick;
    logic [7*DIGITS-1:0]   w_hex_next;
    logic [DIGITS:0]       w_zero_above;

    // LOAD restarts the step period so the next step is a full period later.
    tick_divider #(.DIV(CLK_HZ / COUNT_HZ)) u_count_div (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .clr      (LOAD),
        .tick     (w_step)
    );

    tick_divider #(.DIV(CLK_HZ / (2 * BLINK_HZ))) u_blink_div (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .clr      (1'b0),
        .tick     (w_blink_tick)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_val  <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (LOAD) begin
                r_val <= VALUE;
            end else if (w_step) begin
                case (MODE)
                    MODE_UP: begin
                        r_val  <= r_val + 1'b1;
                        r_tick <= 1'b1;
                        r_wrap <= (r_val == ALL_F);
                    end
                    MODE_DOWN: begin
                        r_val  <= r_val - 1'b1;
                        r_tick <= 1'b1;
                        r_wrap <= (r_val == '0);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_phase <= 1'b0;
        end else if (w_blink_tick) begin
            r_phase <= ~r_phase;
        end
    end

    // w_zero_above[i]: digit i and every digit above it are zero.
    assign w_zero_above[DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [6:0] w_seg;
            logic       w_lz;
            logic       w_blank;

            seven_segment_display u_dec (
                .X   (r_val[4*gi +: 4]),
                .HEX (w_seg)
            );

            assign w_zero_above[gi] = w_zero_above[gi+1] & (r_val[4*gi +: 4] == 4'h0);

            if (gi == 0) begin : g_lsd
                assign w_lz = 1'b0;
            end else begin : g_upper
                assign w_lz = BLANK_LZ & w_zero_above[gi];
            end

            assign w_blank                = (BLINK_EN & r_phase) | w_lz;
            assign w_hex_next[7*gi +: 7]  = w_blank ? SEG_BLANK : w_seg;
        end
    endgenerate

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_hex <= {DIGITS{SEG_BLANK}};
        end else begin
            r_hex <= w_hex_next;
        end
    end

    assign HEX  = r_hex;
    assign LEDR = r_val;
    assign TICK = r_tick;
    assign WRAP = r_wrap;

endmodule
